rev_add32_seq: RTL and testbench

Sequencing controller that performs 32-bit additions by driving the 16-bit reversible adder twice per operation: low halfword first, then high halfword with the registered carry. It sits directly around the 16-bit reversible adder. It feeds that adder's operand and carry inputs and consumes its Sum, Cout and restored-operand outputs. It presents a valid/ready transaction interface to upstream and downstream logic, and optionally checks that the adder's restored operands match what was driven.

---
 rtl/rev_add32_seq_if.sv | 38 +++
 rtl/rev_add32_seq.sv | 164 ++++++++++++++++
 tb/tb_rev_add32_seq.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rev_add32_seq_if.sv
// rev_add32_seq_if
//   Transaction bundle between rev_add32_seq and its upstream/downstream logic.
//   Parameter CNT_W : width of the completed-operation counter (op_count).
//   Signals:
//     in_valid / in_ready   upstream operation handshake
//     a, b, cin             32-bit operands and carry-in
//     out_valid / out_ready downstream result handshake
//     sum, cout             32-bit result and carry-out of bit 31
//     rev_err               restored-operand mismatch flag for this result
//     op_count              completed result handshakes, modulo 2^CNT_W
//   Modports:
//     master : the side that issues operations and consumes results
//     slave  : the controller (rev_add32_seq)
interface rev_add32_seq_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      a;
    logic [31:0]      b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      sum;
    logic             cout;
    logic             rev_err;
    logic [CNT_W-1:0] op_count;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, rev_err, op_count
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, rev_err, op_count
    );
endinterface

// File: rtl/rev_add32_seq.sv
// rev_add32_seq
//   Performs a 32-bit addition {cout,sum} = a + b + cin by driving an external
//   combinational 16-bit reversible adder twice: low halfword first, then the
//   high halfword with the carry produced by the low pass.
//
//   Ports:
//     clk       sole clock, rising edge
//     rst_n     synchronous, active-low reset
//     bus       rev_add32_seq_if.slave (valid/ready operation in, result out,
//               rev_err flag, op_count)
//     add_a/add_b/add_cin   operand halves and carry driven to the adder
//     add_sum/add_cout      adder result
//     add_aout/add_bout     adder restored operands
//
//   Optional feature (macro REV_CHECK_EN): when defined, the restored operands
//   are compared with what was driven during both adder passes and any
//   mismatch is reported on rev_err with the result. When undefined, the
//   comparison is absent, rev_err is 0 and add_aout/add_bout are ignored.
//
//   FSM: IDLE -> LO -> HI -> DONE -> IDLE. Every output is a register, so the
//   adder drive values are loaded on the edge that enters the state using them.
module rev_add32_seq #(
    parameter int CNT_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    rev_add32_seq_if.slave bus,
    output logic [15:0] add_a,
    output logic [15:0] add_b,
    output logic        add_cin,
    input  logic [15:0] add_sum,
    input  logic        add_cout,
    input  logic [15:0] add_aout,
    input  logic [15:0] add_bout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_reg;
    // Only the upper halves need holding: the lower halves go straight into
    // the add_a/add_b registers on the accept edge.
    logic [15:0]      a_hi_reg;
    logic [15:0]      b_hi_reg;
    logic [31:0]      sum_reg;
    logic             cout_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;
    logic [CNT_W-1:0] op_count_reg;
    logic [15:0]      add_a_reg;
    logic [15:0]      add_b_reg;
    logic             add_cin_reg;

`ifdef REV_CHECK_EN
    logic             err_reg;
    logic             rev_err_reg;
    logic             mismatch;

    // add_a_reg/add_b_reg are exactly what the adder sees this cycle.
    assign mismatch = (add_aout != add_a_reg) || (add_bout != add_b_reg);
`else
    logic             unused_restored;

    assign unused_restored = ^{add_aout, add_bout};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            a_hi_reg      <= '0;
            b_hi_reg      <= '0;
            sum_reg       <= '0;
            cout_reg      <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            op_count_reg  <= '0;
            add_a_reg     <= '0;
            add_b_reg     <= '0;
            add_cin_reg   <= 1'b0;
`ifdef REV_CHECK_EN
            err_reg       <= 1'b0;
            rev_err_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid && in_ready_reg) begin
                        a_hi_reg     <= bus.a[31:16];
                        b_hi_reg     <= bus.b[31:16];
                        add_a_reg    <= bus.a[15:0];
                        add_b_reg    <= bus.b[15:0];
                        add_cin_reg  <= bus.cin;
                        in_ready_reg <= 1'b0;
`ifdef REV_CHECK_EN
                        err_reg      <= 1'b0;
`endif
                        state_reg    <= LO;
                    end
                end
                LO: begin
                    sum_reg[15:0] <= add_sum;
                    // The low-pass carry is loaded directly as the high-pass
                    // carry input; it doubles as the registered carry.
                    add_a_reg     <= a_hi_reg;
                    add_b_reg     <= b_hi_reg;
                    add_cin_reg   <= add_cout;
`ifdef REV_CHECK_EN
                    err_reg       <= err_reg | mismatch;
`endif
                    state_reg     <= HI;
                end
                HI: begin
                    sum_reg[31:16] <= add_sum;
                    cout_reg       <= add_cout;
                    add_a_reg      <= '0;
                    add_b_reg      <= '0;
                    add_cin_reg    <= 1'b0;
                    out_valid_reg  <= 1'b1;
`ifdef REV_CHECK_EN
                    err_reg        <= err_reg | mismatch;
                    rev_err_reg    <= err_reg | mismatch;
`endif
                    state_reg      <= DONE;
                end
                DONE: begin
                    // in_ready stays low here so a new accept can never share
                    // the result-handshake edge.
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        op_count_reg  <= op_count_reg + CNT_W'(1);
`ifdef REV_CHECK_EN
                        rev_err_reg   <= 1'b0;
`endif
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.sum       = sum_reg;
    assign bus.cout      = cout_reg;
    assign bus.op_count  = op_count_reg;
`ifdef REV_CHECK_EN
    assign bus.rev_err   = rev_err_reg;
`else
    assign bus.rev_err   = 1'b0;
`endif

    assign add_a   = add_a_reg;
    assign add_b   = add_b_reg;
    assign add_cin = add_cin_reg;

endmodule

// File: tb/tb_rev_add32_seq.sv
// tb_rev_add32_seq
//   Bench for rev_add32_seq. Two instances run in lockstep from the same
//   stimulus: dut (CNT_W=8) is fully checked, dut2 (CNT_W=2) is used for the
//   op_count wrap sequence. Each instance has a behavioural 16-bit adder; the
//   adder of dut can corrupt add_bout[3] during the high pass on request.
//   Build with +define+REV_CHECK_EN to enable the restored-operand check.
module tb_rev_add32_seq;

    logic clk;
    logic rst_n;

    rev_add32_seq_if #(.CNT_W(8)) bus ();
    rev_add32_seq_if #(.CNT_W(2)) bus2 ();

    logic [15:0] add_a1, add_b1, add_sum1, add_aout1, add_bout1;
    logic        add_cin1, add_cout1;
    logic [15:0] add_a2, add_b2, add_sum2, add_aout2, add_bout2;
    logic        add_cin2, add_cout2;
    logic        inject;
    logic [16:0] s1, s2;

    rev_add32_seq #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave),
        .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1),
        .add_sum(add_sum1), .add_cout(add_cout1),
        .add_aout(add_aout1), .add_bout(add_bout1)
    );

    rev_add32_seq #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2.slave),
        .add_a(add_a2), .add_b(add_b2), .add_cin(add_cin2),
        .add_sum(add_sum2), .add_cout(add_cout2),
        .add_aout(add_aout2), .add_bout(add_bout2)
    );

    assign bus2.in_valid  = bus.in_valid;
    assign bus2.a         = bus.a;
    assign bus2.b         = bus.b;
    assign bus2.cin       = bus.cin;
    assign bus2.out_ready = bus.out_ready;

    // Behavioural adders. Corruption only hits dut's adder when its high
    // operand half is 0x1234, i.e. the high pass of a=0x12345678.
    always_comb begin
        s1 = {1'b0, add_a1} + {1'b0, add_b1} + 17'(add_cin1);
        s2 = {1'b0, add_a2} + {1'b0, add_b2} + 17'(add_cin2);
    end
    assign add_sum1  = s1[15:0];
    assign add_cout1 = s1[16];
    assign add_aout1 = add_a1;
    assign add_bout1 = add_b1 ^ ((inject && add_a1 == 16'h1234) ? 16'h0008 : 16'h0000);
    assign add_sum2  = s2[15:0];
    assign add_cout2 = s2[16];
    assign add_aout2 = add_a2;
    assign add_bout2 = add_b2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        err;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        int          hold;
        logic [31:0] esum;
        logic        ecout;
    } vec_t;
    vec_t vecs[7];

    logic exp_rev;

    function automatic void check(string name, logic [32:0] act, logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void pop_check();
        exp_t e;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: result with no pending expectation");
        end else begin
            e = sbq.pop_front();
            check("sum", 33'(bus.sum), 33'(e.sum));
            check("cout", 33'(bus.cout), 33'(e.cout));
            check("rev_err", 33'(bus.rev_err), 33'(e.err));
            $display("result sum=0x%08h cout=%0b rev_err=%0b (expect 0x%08h %0b %0b)",
                     bus.sum, bus.cout, bus.rev_err, e.sum, e.cout, e.err);
        end
    endfunction

    // One full operation; all driving and sampling happens on negedges.
    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic tcin,
                         input int hold, input logic inj, input logic exp_err,
                         input logic [31:0] esum, input logic ecout);
        logic [16:0] lo;
        logic [7:0]  cnt0;
        logic [1:0]  cnt2;
        logic [31:0] s0;
        logic        c0;
        int          n;
        lo = {1'b0, ta[15:0]} + {1'b0, tb_v[15:0]} + 17'(tcin);
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", 33'(bus.in_ready), 33'd1);
        $display("op a=0x%08h b=0x%08h cin=%0b hold=%0d inject=%0b", ta, tb_v, tcin, hold, inj);
        cnt0 = bus.op_count;
        cnt2 = bus2.op_count;
        bus.a        = ta;
        bus.b        = tb_v;
        bus.cin      = tcin;
        bus.in_valid = 1'b1;
        inject       = inj;
        sbq.push_back('{sum: esum, cout: ecout, err: exp_err});
        @(negedge clk);                       // LO
        bus.in_valid = 1'b0;
        bus.a        = $urandom;              // must not disturb the captured operands
        bus.b        = $urandom;
        check("lo_in_ready", 33'(bus.in_ready), 33'd0);
        check("lo_out_valid", 33'(bus.out_valid), 33'd0);
        check("lo_add_a", 33'(add_a1), 33'(ta[15:0]));
        check("lo_add_b", 33'(add_b1), 33'(tb_v[15:0]));
        check("lo_add_cin", 33'(add_cin1), 33'(tcin));
        @(negedge clk);                       // HI
        check("hi_out_valid", 33'(bus.out_valid), 33'd0);
        check("hi_add_a", 33'(add_a1), 33'(ta[31:16]));
        check("hi_add_b", 33'(add_b1), 33'(tb_v[31:16]));
        check("hi_add_cin", 33'(add_cin1), 33'(lo[16]));
        @(negedge clk);                       // DONE
        check("latency_out_valid", 33'(bus.out_valid), 33'd1);
        check("done_add_a", 33'(add_a1), 33'd0);
        s0 = bus.sum;
        c0 = bus.cout;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_out_valid", 33'(bus.out_valid), 33'd1);
            check("hold_in_ready", 33'(bus.in_ready), 33'd0);
            check("hold_sum", 33'(bus.sum), 33'(s0));
            check("hold_cout", 33'(bus.cout), 33'(c0));
            check("hold_op_count", 33'(bus.op_count), 33'(cnt0));
        end
        pop_check();
        bus.out_ready = 1'b1;
        @(negedge clk);                       // back in IDLE
        bus.out_ready = 1'b0;
        inject        = 1'b0;
        check("op_count", 33'(bus.op_count), 33'(8'(cnt0 + 8'd1)));
        check("op_count_w2", 33'(bus2.op_count), 33'(2'(cnt2 + 2'd1)));
        check("post_out_valid", 33'(bus.out_valid), 33'd0);
        check("post_in_ready", 33'(bus.in_ready), 33'd1);
    endtask

    initial begin
        logic [32:0] full;
        logic [31:0] ra, rb;
        logic        rc;
        logic [1:0]  seq2 [5];
        int          n;

        vecs[0] = '{a: 32'h0000FFFF, b: 32'h00000001, cin: 1'b0, hold: 0, esum: 32'h00010000, ecout: 1'b0};
        vecs[1] = '{a: 32'hFFFFFFFF, b: 32'h00000000, cin: 1'b1, hold: 0, esum: 32'h00000000, ecout: 1'b1};
        vecs[2] = '{a: 32'h12345678, b: 32'h11111111, cin: 1'b0, hold: 5, esum: 32'h23456789, ecout: 1'b0};
        vecs[3] = '{a: 32'h80000000, b: 32'h80000000, cin: 1'b0, hold: 0, esum: 32'h00000000, ecout: 1'b1};
        vecs[4] = '{a: 32'h7FFFFFFF, b: 32'h00000001, cin: 1'b0, hold: 1, esum: 32'h80000000, ecout: 1'b0};
        vecs[5] = '{a: 32'hFFFF0000, b: 32'h0000FFFF, cin: 1'b1, hold: 0, esum: 32'h00000000, ecout: 1'b1};
        vecs[6] = '{a: 32'hDEADBEEF, b: 32'h12345678, cin: 1'b1, hold: 2, esum: 32'hF0E21568, ecout: 1'b0};
        seq2[0] = 2'd1; seq2[1] = 2'd2; seq2[2] = 2'd3; seq2[3] = 2'd0; seq2[4] = 2'd1;

`ifdef REV_CHECK_EN
        exp_rev = 1'b1;
`else
        exp_rev = 1'b0;
`endif

        rst_n         = 1'b0;
        inject        = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 33'(bus.in_ready), 33'd1);
        check("rst_out_valid", 33'(bus.out_valid), 33'd0);
        check("rst_sum", 33'(bus.sum), 33'd0);
        check("rst_cout", 33'(bus.cout), 33'd0);
        check("rst_rev_err", 33'(bus.rev_err), 33'd0);
        check("rst_op_count", 33'(bus.op_count), 33'd0);
        check("rst_add_a", 33'(add_a1), 33'd0);
        check("rst_add_b", 33'(add_b1), 33'd0);
        check("rst_add_cin", 33'(add_cin1), 33'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven vectors.
        for (int i = 0; i < 7; i++)
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].hold, 1'b0, 1'b0,
                  vecs[i].esum, vecs[i].ecout);

        // Restored-operand corruption in the high pass, then a clean operation.
        do_op(32'h12345678, 32'h11111111, 1'b0, 0, 1'b1, exp_rev, 32'h23456789, 1'b0);
        do_op(32'h12345678, 32'h11111111, 1'b0, 0, 1'b0, 1'b0, 32'h23456789, 1'b0);

        // Random operations checked against a 33-bit model.
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            full = {1'b0, ra} + {1'b0, rb} + 33'(rc);
            do_op(ra, rb, rc, i % 3, 1'b0, 1'b0, full[31:0], full[32]);
        end

        // Reset while in HI discards the operation and clears op_count.
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        $display("op a=0x0F0F0F0F b=0x01010101 cin=0 aborted by reset in HI");
        bus.a        = 32'h0F0F0F0F;
        bus.b        = 32'h01010101;
        bus.in_valid = 1'b1;
        @(negedge clk);                       // LO
        bus.in_valid = 1'b0;
        @(negedge clk);                       // HI
        check("pre_rst_add_a", 33'(add_a1), 33'h0F0F);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_in_ready", 33'(bus.in_ready), 33'd1);
        check("midrst_out_valid", 33'(bus.out_valid), 33'd0);
        check("midrst_op_count", 33'(bus.op_count), 33'd0);
        check("midrst_op_count_w2", 33'(bus2.op_count), 33'd0);
        check("midrst_add_a", 33'(add_a1), 33'd0);
        @(negedge clk);
        check("midrst_still_idle", 33'(bus.out_valid), 33'd0);

        // Five back-to-back operations: the 2-bit counter must read 1,2,3,0,1.
        for (int i = 0; i < 5; i++) begin
            ra = 32'h0001_0000 * 32'(i + 1) + 32'hFFFF;
            rb = 32'h0000_0001;
            full = {1'b0, ra} + {1'b0, rb};
            do_op(ra, rb, 1'b0, 0, 1'b0, 1'b0, full[31:0], full[32]);
            check("wrap_seq", 33'(bus2.op_count), 33'(seq2[i]));
        end

        check("scoreboard_empty", 33'(sbq.size()), 33'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
